// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue/collect controller: pipe depth, ctrl width,
// FSM states and the default result-entry layout.
package alu_issue_pkg;

    localparam int ALU_LATENCY = 3;
    localparam int ALU_CTRL_W  = 8;
    localparam int RES_DATA_W  = 16;
    localparam int RES_TAG_W   = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        WAIT,
        DONE
    } issue_state_t;

    typedef struct packed {
        logic [RES_DATA_W-1:0] data;
        logic                  cout;
        logic [RES_TAG_W-1:0]  tag;
    } alu_res_t;

endpackage

// File: rtl/alu_res_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible whenever not empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module alu_res_fifo
    import alu_issue_pkg::*;
#(
    parameter type ENTRY_T = alu_res_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  ENTRY_T i_din,
    input  logic   i_pop,
    output ENTRY_T o_head,
    output logic   o_full,
    output logic   o_empty
);
    localparam int AW = $clog2(DEPTH);

    ENTRY_T          r_mem [DEPTH];
    logic   [AW:0]   r_wr_ptr;
    logic   [AW:0]   r_rd_ptr;
    logic            w_wr_en;
    logic            w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller for the 3-stage enable-only ALU pipe, with flush/drain FSM.
// Optional ALU_ISSUE_CTRL_PERF_EN adds perf_issued / perf_stall counters.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int TAG_W     = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [REG_WIDTH-1:0]  op_a,
    input  logic [REG_WIDTH-1:0]  op_b,
    input  logic [ALU_CTRL_W-1:0] op_ctrl,
    input  logic                  op_cin,
    input  logic [TAG_W-1:0]      op_tag,
    output logic [REG_WIDTH-1:0]  alu_a,
    output logic [REG_WIDTH-1:0]  alu_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_cin,
    output logic                  alu_pipe_active,
    input  logic [REG_WIDTH-1:0]  alu_out,
    input  logic                  alu_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [REG_WIDTH-1:0]  res_data,
    output logic                  res_cout,
    output logic [TAG_W-1:0]      res_tag,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  busy
`ifdef ALU_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall
`endif
);
    typedef struct packed {
        logic [REG_WIDTH-1:0] data;
        logic                 cout;
        logic [TAG_W-1:0]     tag;
    } res_t;

    issue_state_t           r_state;
    logic                   r_live;
    logic [ALU_LATENCY-1:0] r_v;
    logic [TAG_W-1:0]       r_tg [ALU_LATENCY];

    logic w_full;
    logic w_empty;
    logic w_stall;
    logic w_adv;
    logic w_hs;
    logic w_push;
    logic w_pop;
    res_t w_push_data;
    res_t w_head;

    // r_live holds the pipe and op_ready low while reset is asserted.
    assign w_stall         = r_v[ALU_LATENCY-1] & w_full;
    assign w_adv           = r_live & ~w_stall;
    assign alu_pipe_active = w_adv;
    assign op_ready        = w_adv & (r_state == RUN) & ~flush_req;
    assign w_hs            = op_valid & op_ready;
    assign w_push          = w_adv & r_v[ALU_LATENCY-1];
    assign w_pop           = res_valid & res_ready;

    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_ctrl = op_ctrl;
    assign alu_cin  = op_cin;

    assign w_push_data = '{data: alu_out, cout: alu_cout, tag: r_tg[ALU_LATENCY-1]};

    assign res_valid  = ~w_empty;
    assign res_data   = w_empty ? '0 : w_head.data;
    assign res_cout   = w_empty ? 1'b0 : w_head.cout;
    assign res_tag    = w_empty ? '0 : w_head.tag;
    assign busy       = (|r_v) | ~w_empty;
    assign flush_done = (r_state == DONE);

    alu_res_fifo #(
        .ENTRY_T (res_t),
        .DEPTH   (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Shadow valid/tag pipe mirrors the ALU stages and moves only with the ALU enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
            r_v    <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) r_tg[i] <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_adv) begin
                r_v     <= {r_v[ALU_LATENCY-2:0], w_hs};
                r_tg[0] <= op_tag;
                for (int i = 1; i < ALU_LATENCY; i++) r_tg[i] <= r_tg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (flush_req)  r_state <= DRAIN;
                DRAIN:   if (r_v == '0)  r_state <= WAIT;
                WAIT:    if (w_empty)    r_state <= DONE;
                DONE:                    r_state <= RUN;
                default:                 r_state <= RUN;
            endcase
        end
    end

`ifdef ALU_ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_hs)   perf_issued <= perf_issued + 32'd1;
            if (!w_adv) perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
